// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit accumulation, per-item price and stock,
// selection/vend, change return, cancel and inactivity-timeout refund.
//   state   | meaning
//   IDLE    | no credit; restock allowed, first coin opens a session
//   COLLECT | accumulating credit, waiting for selection/cancel/timeout
//   VEND    | one-cycle dispense pulse
//   CHANGE  | one-cycle change pulse, credit cleared
module vending_machine_multi #(
  parameter int                            NUM_ITEMS = 4,
  parameter int                            STOCK_W   = 4,
  parameter int                            CREDIT_W  = 6,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES    = {6'd7, 6'd5, 6'd3, 6'd2},
  parameter int                            TIMEOUT   = 255,
  localparam int                           ID_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coin_valid,
  input  logic [1:0]                   coin_val,
  input  logic                         sel_valid,
  input  logic [ID_W-1:0]              sel_id,
  input  logic                         cancel,
  input  logic                         load_en,
  input  logic [ID_W-1:0]              load_id,
  input  logic [STOCK_W-1:0]           load_qty,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         deliver,
  output logic [ID_W-1:0]              deliver_id,
  output logic                         change_valid,
  output logic [CREDIT_W-1:0]          change_amt,
  output logic                         coin_reject,
  output logic                         err_sold_out,
  output logic                         err_funds,
  output logic [NUM_ITEMS*STOCK_W-1:0] stock,
  output logic                         busy
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t              state;
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
  logic [TMR_W-1:0]    timer;

  logic [CREDIT_W-1:0] coin_amt;
  logic                coin_ok;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic [STOCK_W-1:0]  sel_stock;
  logic [CREDIT_W-1:0] sel_price;

  always_comb begin
    coin_amt = '0;
    coin_ok  = 1'b1;
    case (coin_val)
      2'b00:   coin_amt = CREDIT_W'(1);
      2'b01:   coin_amt = CREDIT_W'(2);
      2'b10:   coin_amt = CREDIT_W'(5);
      default: coin_ok  = 1'b0;
    endcase
    coin_sum  = {1'b0, credit} + {1'b0, coin_amt};
    coin_fits = ~coin_sum[CREDIT_W];
  end

  // Out-of-range ids read as stock 0, so they are refused as sold out.
  always_comb begin
    sel_stock = '0;
    sel_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_id == ID_W'(i)) begin
        sel_stock = stock_q[i];
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_stock
    assign stock[g*STOCK_W +: STOCK_W] = stock_q[g];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      credit       <= '0;
      timer        <= '0;
      deliver      <= 1'b0;
      deliver_id   <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      err_sold_out <= 1'b0;
      err_funds    <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= '0;
    end else begin
      deliver      <= 1'b0;
      deliver_id   <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      err_sold_out <= 1'b0;
      err_funds    <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) begin
            for (int i = 0; i < NUM_ITEMS; i++)
              if (load_id == ID_W'(i)) stock_q[i] <= load_qty;
          end
          if (cancel) begin
            coin_reject <= coin_valid;
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            if (sel_stock == '0) err_sold_out <= 1'b1;
            else                 err_funds    <= 1'b1;
          end else if (coin_valid) begin
            if (coin_ok) begin
              credit <= coin_amt;
              timer  <= TMR_W'(TIMEOUT);
              state  <= COLLECT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (cancel || (!sel_valid && !coin_valid && timer == '0)) begin
            coin_reject  <= coin_valid;
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= '0;
            state        <= CHANGE;
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            timer       <= TMR_W'(TIMEOUT);
            if (sel_stock == '0) begin
              err_sold_out <= 1'b1;
            end else if (credit < sel_price) begin
              err_funds <= 1'b1;
            end else begin
              for (int i = 0; i < NUM_ITEMS; i++)
                if (sel_id == ID_W'(i)) stock_q[i] <= stock_q[i] - 1'b1;
              credit     <= credit - sel_price;
              deliver    <= 1'b1;
              deliver_id <= sel_id;
              state      <= VEND;
            end
          end else if (coin_valid) begin
            timer <= TMR_W'(TIMEOUT);
            if (coin_ok && coin_fits) credit      <= coin_sum[CREDIT_W-1:0];
            else                      coin_reject <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        VEND: begin
          coin_reject <= coin_valid;
          if (credit != '0) begin
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= '0;
            state        <= CHANGE;
          end else begin
            state <= IDLE;
          end
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi with hand-computed expectations.
module tb_vending_machine_multi;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic        coin_valid;
  logic [1:0]  coin_val;
  logic        sel_valid;
  logic [1:0]  sel_id;
  logic        cancel;
  logic        load_en;
  logic [1:0]  load_id;
  logic [3:0]  load_qty;
  logic [5:0]  credit;
  logic        deliver;
  logic [1:0]  deliver_id;
  logic        change_valid;
  logic [5:0]  change_amt;
  logic        coin_reject;
  logic        err_sold_out;
  logic        err_funds;
  logic [15:0] stock;
  logic        busy;

  int total = 0;
  int bad   = 0;

  vending_machine_multi dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_id(sel_id),
    .cancel(cancel),
    .load_en(load_en), .load_id(load_id), .load_qty(load_qty),
    .credit(credit), .deliver(deliver), .deliver_id(deliver_id),
    .change_valid(change_valid), .change_amt(change_amt),
    .coin_reject(coin_reject), .err_sold_out(err_sold_out), .err_funds(err_funds),
    .stock(stock), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    coin_valid = 1'b0; coin_val = 2'b00; sel_valid = 1'b0; sel_id = '0;
    cancel = 1'b0; load_en = 1'b0; load_id = '0; load_qty = '0;
  endtask

  task automatic coin(input logic [1:0] v);
    coin_valid = 1'b1; coin_val = v;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [1:0] id);
    sel_valid = 1'b1; sel_id = id;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic load(input logic [1:0] id, input logic [3:0] qty);
    load_en = 1'b1; load_id = id; load_qty = qty;
    tick();
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    coin_valid = 1'b1; coin_val = 2'b10;
    tick(); tick();
    total++; if (credit !== 6'd0) begin bad++; $display("FAIL reset_credit: got %0d want 0", credit); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (stock !== 16'h0) begin bad++; $display("FAIL reset_stock: got %h want 0000", stock); end
    total++;
    if ({deliver, change_valid, coin_reject, err_sold_out, err_funds} !== 5'b0) begin
      bad++; $display("FAIL reset_pulses: got %b want 00000",
                      {deliver, change_valid, coin_reject, err_sold_out, err_funds});
    end
    clear_inputs();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_vend_with_change();
    load(2'd2, 4'd3);
    total++; if (stock[11:8] !== 4'd3) begin bad++; $display("FAIL t1_load: got %0d want 3", stock[11:8]); end
    coin(2'b10);
    total++; if (credit !== 6'd5 || busy !== 1'b1) begin bad++; $display("FAIL t1_coin5: got credit=%0d busy=%0b want 5 1", credit, busy); end
    coin(2'b01);
    total++; if (credit !== 6'd7) begin bad++; $display("FAIL t1_coin2: got %0d want 7", credit); end
    select(2'd2);
    total++;
    if (deliver !== 1'b1 || deliver_id !== 2'd2 || credit !== 6'd2 || stock[11:8] !== 4'd2) begin
      bad++; $display("FAIL t1_deliver: got deliver=%0b id=%0d credit=%0d stock2=%0d want 1 2 2 2",
                      deliver, deliver_id, credit, stock[11:8]);
    end
    tick();
    total++;
    if (change_valid !== 1'b1 || change_amt !== 6'd2 || deliver !== 1'b0 || deliver_id !== 2'd0) begin
      bad++; $display("FAIL t1_change: got cv=%0b amt=%0d deliver=%0b id=%0d want 1 2 0 0",
                      change_valid, change_amt, deliver, deliver_id);
    end
    tick();
    total++;
    if (change_valid !== 1'b0 || change_amt !== 6'd0 || busy !== 1'b0 || credit !== 6'd0) begin
      bad++; $display("FAIL t1_idle: got cv=%0b amt=%0d busy=%0b credit=%0d want 0 0 0 0",
                      change_valid, change_amt, busy, credit);
    end
  endtask

  task automatic test_funds();
    load(2'd1, 4'd1);
    coin(2'b00);
    coin(2'b00);
    total++; if (credit !== 6'd2) begin bad++; $display("FAIL t2_credit2: got %0d want 2", credit); end
    select(2'd1);
    total++;
    if (err_funds !== 1'b1 || err_sold_out !== 1'b0 || credit !== 6'd2 || deliver !== 1'b0) begin
      bad++; $display("FAIL t2_err_funds: got ef=%0b eso=%0b credit=%0d deliver=%0b want 1 0 2 0",
                      err_funds, err_sold_out, credit, deliver);
    end
    coin(2'b00);
    select(2'd1);
    total++;
    if (deliver !== 1'b1 || deliver_id !== 2'd1 || credit !== 6'd0 || stock[7:4] !== 4'd0) begin
      bad++; $display("FAIL t2_deliver: got deliver=%0b id=%0d credit=%0d stock1=%0d want 1 1 0 0",
                      deliver, deliver_id, credit, stock[7:4]);
    end
    tick();
    total++;
    if (change_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t2_no_change: got cv=%0b busy=%0b want 0 0", change_valid, busy);
    end
  endtask

  task automatic test_sold_out_cancel();
    coin(2'b10);
    select(2'd0);
    total++;
    if (err_sold_out !== 1'b1 || err_funds !== 1'b0 || credit !== 6'd5) begin
      bad++; $display("FAIL t3_sold_out: got eso=%0b ef=%0b credit=%0d want 1 0 5",
                      err_sold_out, err_funds, credit);
    end
    cancel = 1'b1; tick(); cancel = 1'b0;
    total++;
    if (change_valid !== 1'b1 || change_amt !== 6'd5) begin
      bad++; $display("FAIL t3_refund: got cv=%0b amt=%0d want 1 5", change_valid, change_amt);
    end
    tick();
    total++; if (credit !== 6'd0 || busy !== 1'b0) begin bad++; $display("FAIL t3_idle: got credit=%0d busy=%0b want 0 0", credit, busy); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 12; i++) coin(2'b10);
    total++; if (credit !== 6'd60) begin bad++; $display("FAIL t4_credit60: got %0d want 60", credit); end
    coin(2'b10);
    total++;
    if (coin_reject !== 1'b1 || credit !== 6'd60) begin
      bad++; $display("FAIL t4_overflow: got rej=%0b credit=%0d want 1 60", coin_reject, credit);
    end
    coin(2'b11);
    total++;
    if (coin_reject !== 1'b1 || credit !== 6'd60) begin
      bad++; $display("FAIL t4_invalid: got rej=%0b credit=%0d want 1 60", coin_reject, credit);
    end
    coin_valid = 1'b1; coin_val = 2'b10; cancel = 1'b1;
    tick();
    coin_valid = 1'b0; cancel = 1'b0;
    total++;
    if (coin_reject !== 1'b1 || change_valid !== 1'b1 || change_amt !== 6'd60) begin
      bad++; $display("FAIL t4_coin_cancel: got rej=%0b cv=%0b amt=%0d want 1 1 60",
                      coin_reject, change_valid, change_amt);
    end
    tick();
  endtask

  task automatic test_max_credit();
    for (int i = 0; i < 12; i++) coin(2'b10);
    coin(2'b01);
    coin(2'b00);
    total++;
    if (credit !== 6'd63 || coin_reject !== 1'b0) begin
      bad++; $display("FAIL max_exact: got credit=%0d rej=%0b want 63 0", credit, coin_reject);
    end
    coin(2'b00);
    total++;
    if (credit !== 6'd63 || coin_reject !== 1'b1) begin
      bad++; $display("FAIL max_over: got credit=%0d rej=%0b want 63 1", credit, coin_reject);
    end
    cancel = 1'b1; tick(); cancel = 1'b0;
    total++; if (change_amt !== 6'd63) begin bad++; $display("FAIL max_refund: got %0d want 63", change_amt); end
    tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    coin(2'b00);
    coin(2'b01);
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (change_valid !== 1'b0) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL t5_early: got %0d early change cycles want 0", early); end
    tick();
    total++;
    if (change_valid !== 1'b1 || change_amt !== 6'd3) begin
      bad++; $display("FAIL t5_timeout: got cv=%0b amt=%0d want 1 3", change_valid, change_amt);
    end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_idle: got busy=%0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    load(2'd0, 4'd1);
    coin(2'b01);
    coin(2'b00);
    select(2'd0);
    total++;
    if (deliver !== 1'b1 || deliver_id !== 2'd0 || credit !== 6'd1 || stock[3:0] !== 4'd0) begin
      bad++; $display("FAIL b2b_deliver: got deliver=%0b id=%0d credit=%0d stock0=%0d want 1 0 1 0",
                      deliver, deliver_id, credit, stock[3:0]);
    end
    coin(2'b10);
    total++;
    if (coin_reject !== 1'b1 || change_valid !== 1'b1 || change_amt !== 6'd1) begin
      bad++; $display("FAIL b2b_vend_coin: got rej=%0b cv=%0b amt=%0d want 1 1 1",
                      coin_reject, change_valid, change_amt);
    end
    tick();
    select(2'd0);
    total++;
    if (err_sold_out !== 1'b1 || err_funds !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle_sold_out: got eso=%0b ef=%0b busy=%0b want 1 0 0",
                      err_sold_out, err_funds, busy);
    end
    select(2'd2);
    total++;
    if (err_funds !== 1'b1 || err_sold_out !== 1'b0 || stock[3:0] !== 4'd0) begin
      bad++; $display("FAIL b2b_idle_funds: got ef=%0b eso=%0b stock0=%0d want 1 0 0",
                      err_funds, err_sold_out, stock[3:0]);
    end
  endtask

  task automatic test_reset_mid_vend();
    load(2'd3, 4'd2);
    coin(2'b10);
    coin(2'b01);
    select(2'd3);
    total++; if (deliver !== 1'b1 || deliver_id !== 2'd3) begin bad++; $display("FAIL t6_deliver: got deliver=%0b id=%0d want 1 3", deliver, deliver_id); end
    rst = 1'b0;
    #1;
    total++;
    if (deliver !== 1'b0 || deliver_id !== 2'd0 || busy !== 1'b0 || credit !== 6'd0 || stock !== 16'h0) begin
      bad++; $display("FAIL t6_async_reset: got deliver=%0b id=%0d busy=%0b credit=%0d stock=%h want 0 0 0 0 0000",
                      deliver, deliver_id, busy, credit, stock);
    end
    #2;
    rst = 1'b1;
    tick();
    total++; if (change_valid !== 1'b0) begin bad++; $display("FAIL t6_no_change: got cv=%0b want 0", change_valid); end
    coin(2'b00);
    load(2'd0, 4'd5);
    total++;
    if (stock !== 16'h0 || busy !== 1'b1) begin
      bad++; $display("FAIL t6_load_ignored: got stock=%h busy=%0b want 0000 1", stock, busy);
    end
    cancel = 1'b1; tick(); cancel = 1'b0;
    total++;
    if (change_valid !== 1'b1 || change_amt !== 6'd1) begin
      bad++; $display("FAIL t6_refund: got cv=%0b amt=%0d want 1 1", change_valid, change_amt);
    end
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_vend_with_change();
    test_funds();
    test_sold_out_cancel();
    test_overflow();
    test_max_credit();
    test_timeout();
    test_back_to_back();
    test_reset_mid_vend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
